// File: rtl/fetch_pkg.sv
// Shared types and defaults for the PC sequencer slice: the two-state run/halt
// enum, default parameter values and the test-entry address function.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int DEF_PC_W         = 16;
  localparam int DEF_N_ENTRY      = 8;
  localparam int DEF_ENTRY_BASE   = 0;
  localparam int DEF_ENTRY_STRIDE = 10;
  localparam int DEF_DEB_CYC      = 4;
  localparam int DEF_CNT_W        = 16;

  // Entry k lives at base + k*stride; out-of-range indices fall back to entry 0.
  // The result is 32 bits wide and the caller keeps the low PC_W bits, which
  // gives the modulo-2^PC_W wrap for any PC_W up to 32.
  function automatic logic [31:0] entry_addr(input logic [31:0] idx,
                                             input logic [31:0] n_entry,
                                             input logic [31:0] base,
                                             input logic [31:0] stride);
    logic [31:0] sel;
    sel = (idx >= n_entry) ? 32'd0 : idx;
    return base + sel * stride;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, level debouncer that needs
// DEB_CYC identical samples before accepting a new level, and a one-clock
// pulse on the accepted falling edge (button release). Runs on the falling
// clock edge like the rest of the sequencer.
module btn_debounce import fetch_pkg::*; #(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic release_pulse
);

  localparam int CW = (DEB_CYC < 1) ? 1 : $clog2(DEB_CYC + 1);

  logic          sync_1;
  logic          sync_2;
  logic          deb_level;
  logic [CW-1:0] deb_cnt;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= button;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive samples that differ from the accepted level; accept on
  // the DEB_CYC-th one and flag a release when the accepted level drops.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      deb_level     <= 1'b0;
      deb_cnt       <= '0;
      release_pulse <= 1'b0;
    end else begin
      release_pulse <= 1'b0;
      if (sync_2 != deb_level) begin
        if (deb_cnt == CW'(DEB_CYC - 1)) begin
          deb_level     <= sync_2;
          deb_cnt       <= '0;
          release_pulse <= deb_level;
        end else begin
          deb_cnt <= deb_cnt + CW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the test harness. Holds the PC, counts
// retired advances, halts on ecall and resumes on a debounced button release.
// All state moves on the falling clock edge so the datapath sees a stable pc
// on the rising edge.
module pc_sequencer import fetch_pkg::*; #(
  parameter int PC_W         = DEF_PC_W,
  parameter int N_ENTRY      = DEF_N_ENTRY,
  parameter int ENTRY_BASE   = DEF_ENTRY_BASE,
  parameter int ENTRY_STRIDE = DEF_ENTRY_STRIDE,
  parameter int DEB_CYC      = DEF_DEB_CYC,
  parameter int CNT_W        = DEF_CNT_W,
  localparam int TN_W        = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ecall,
  input  logic            continue_button,
  input  logic            pc_change,
  input  logic            stall,
  input  logic [PC_W-1:0] target_pc,
  input  logic [TN_W-1:0] test_number,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [PC_W-1:0]  BASE_PC = PC_W'(ENTRY_BASE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             cont_evt;
  logic [31:0]      entry_full;
  logic [PC_W-1:0]  entry_pc;
  logic [CNT_W-1:0] count_next;

  btn_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_btn_debounce (
    .clock        (clock),
    .reset        (reset),
    .button       (continue_button),
    .release_pulse(cont_evt)
  );

  // Selected entry address and saturating count increment.
  always_comb begin
    entry_full = entry_addr(32'(test_number), 32'(N_ENTRY),
                            32'(ENTRY_BASE), 32'(ENTRY_STRIDE));
    count_next = (instr_count == CNT_MAX) ? instr_count : instr_count + CNT_W'(1);
  end

  assign entry_pc = entry_full[PC_W-1:0];

  // Upper bits of the 32-bit entry sum are dropped on purpose (PC wraps).
  if (PC_W < 32) begin : g_entry_trim
    logic unused_entry_hi;
    assign unused_entry_hi = ^entry_full[31:PC_W];
  end

  // Run/halt FSM: pc_change wins, then halt handling, stall, ecall, advance.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      halted      <= 1'b0;
      pc          <= BASE_PC;
      instr_count <= '0;
    end else if (pc_change) begin
      state       <= RUN;
      halted      <= 1'b0;
      pc          <= entry_pc;
      instr_count <= '0;
    end else if (state == HALT) begin
      if (cont_evt) begin
        state       <= RUN;
        halted      <= 1'b0;
        pc          <= target_pc;
        instr_count <= count_next;
      end
    end else if (stall) begin
      pc          <= pc;
    end else if (ecall) begin
      state       <= HALT;
      halted      <= 1'b1;
    end else begin
      pc          <= target_pc;
      instr_count <= count_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of single-edge vectors plus
// hand-written sequences for halt/resume, debounce, saturation and reset.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        ecall;
  logic        continue_button;
  logic        pc_change;
  logic        stall;
  logic [15:0] target_pc;
  logic [2:0]  test_number;
  logic [15:0] pc;
  logic        halted;
  logic [15:0] instr_count;
  logic [15:0] pc4;
  logic        halted4;
  logic [3:0]  instr_count4;
  logic [7:0]  pc_n;
  logic        halted_n;
  logic [15:0] instr_count_n;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        pc_change;
    logic [2:0]  tn;
    logic        stall;
    logic        ecall;
    logic [15:0] tgt;
    logic [15:0] exp_pc;
    logic [15:0] exp_cnt;
    logic        exp_halted;
  } vec_t;

  vec_t vq[$];

  pc_sequencer dut (
    .clock(clock), .reset(reset), .ecall(ecall),
    .continue_button(continue_button), .pc_change(pc_change), .stall(stall),
    .target_pc(target_pc), .test_number(test_number),
    .pc(pc), .halted(halted), .instr_count(instr_count)
  );

  pc_sequencer #(.CNT_W(4)) dut_cnt4 (
    .clock(clock), .reset(reset), .ecall(ecall),
    .continue_button(continue_button), .pc_change(pc_change), .stall(stall),
    .target_pc(target_pc), .test_number(test_number),
    .pc(pc4), .halted(halted4), .instr_count(instr_count4)
  );

  pc_sequencer #(.PC_W(8), .N_ENTRY(5), .ENTRY_BASE(250), .ENTRY_STRIDE(3)) dut_n5 (
    .clock(clock), .reset(reset), .ecall(ecall),
    .continue_button(continue_button), .pc_change(pc_change), .stall(stall),
    .target_pc(target_pc[7:0]), .test_number(test_number),
    .pc(pc_n), .halted(halted_n), .instr_count(instr_count_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic pcc, input logic [2:0] tn, input logic st,
                                input logic ec, input logic [15:0] tgt);
    pc_change   = pcc;
    test_number = tn;
    stall       = st;
    ecall       = ec;
    target_pc   = tgt;
  endtask

  task automatic add_vec(input logic pcc, input logic [2:0] tn, input logic st,
                         input logic ec, input logic [15:0] tgt, input logic [15:0] epc,
                         input logic [15:0] ecnt, input logic eh);
    vec_t v;
    v.pc_change = pcc; v.tn = tn; v.stall = st; v.ecall = ec; v.tgt = tgt;
    v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_halted = eh;
    vq.push_back(v);
  endtask

  task automatic wait_resume(input string name);
    for (int i = 0; i < 20 && halted; i++) tick();
    check_output(name, 32'(halted), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    continue_button = 1'b0;
    apply_stimulus(1'b0, 3'd0, 1'b1, 1'b0, 16'h0000);

    // pc_change, tn, stall, ecall, target -> pc, count, halted
    add_vec(0, 3'd0, 0, 0, 16'h0004, 16'h0004, 16'd1, 0);
    add_vec(0, 3'd0, 0, 0, 16'h0004, 16'h0004, 16'd2, 0);
    add_vec(0, 3'd0, 0, 0, 16'h0004, 16'h0004, 16'd3, 0);
    add_vec(1, 3'd3, 0, 0, 16'h0004, 16'd30,   16'd0, 0);
    add_vec(1, 3'd7, 0, 0, 16'h0004, 16'd70,   16'd0, 0);
    add_vec(0, 3'd0, 0, 0, 16'h1234, 16'h1234, 16'd1, 0);
    add_vec(1, 3'd2, 1, 0, 16'h0055, 16'd20,   16'd0, 0);
    add_vec(0, 3'd0, 1, 0, 16'h0099, 16'd20,   16'd0, 0);
    add_vec(0, 3'd0, 1, 1, 16'h0099, 16'd20,   16'd0, 0);
    add_vec(0, 3'd0, 0, 0, 16'hFFFF, 16'hFFFF, 16'd1, 0);
    add_vec(0, 3'd0, 0, 1, 16'h0100, 16'hFFFF, 16'd1, 1);
    add_vec(0, 3'd0, 0, 0, 16'h0200, 16'hFFFF, 16'd1, 1);
    add_vec(0, 3'd0, 1, 1, 16'h0300, 16'hFFFF, 16'd1, 1);
    add_vec(1, 3'd1, 0, 0, 16'h0300, 16'd10,   16'd0, 0);
    add_vec(0, 3'd0, 0, 0, 16'h0003, 16'h0003, 16'd1, 0);

    // Reset values
    tick(); tick();
    check_output("rst_pc", 32'(pc), 32'h0);
    check_output("rst_cnt", 32'(instr_count), 32'h0);
    check_output("rst_halted", 32'(halted), 32'h0);
    check_output("rst_pc_n5", 32'(pc_n), 32'd250);
    reset = 1'b1;
    tick();
    check_output("rel_hold_pc", 32'(pc), 32'h0);

    // Table-driven single-edge vectors
    foreach (vq[i]) begin
      apply_stimulus(vq[i].pc_change, vq[i].tn, vq[i].stall, vq[i].ecall, vq[i].tgt);
      tick();
      check_output($sformatf("vec%0d_pc", i), 32'(pc), 32'(vq[i].exp_pc));
      check_output($sformatf("vec%0d_cnt", i), 32'(instr_count), 32'(vq[i].exp_cnt));
      check_output($sformatf("vec%0d_halted", i), 32'(halted), 32'(vq[i].exp_halted));
    end

    // Halt on ecall, hold 50 clocks, resume on release of a 10-clock press
    apply_stimulus(0, 3'd0, 0, 1, 16'h0ABC);
    tick();
    check_output("halt_enter", 32'(halted), 32'd1);
    apply_stimulus(0, 3'd0, 1, 0, 16'h0ABC);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 10 == 9) begin
        check_output("halt_hold_pc", 32'(pc), 32'h0003);
        check_output("halt_hold_h", 32'(halted), 32'd1);
      end
    end
    continue_button = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_output("press_no_resume", 32'(halted), 32'd1);
    continue_button = 1'b0;
    wait_resume("release_resume");
    check_output("resume_pc", 32'(pc), 32'h0ABC);
    check_output("resume_cnt", 32'(instr_count), 32'd2);

    // Short glitch in HALT must not resume
    apply_stimulus(0, 3'd0, 0, 1, 16'h0ABC);
    tick();
    apply_stimulus(0, 3'd0, 1, 0, 16'h0DEF);
    continue_button = 1'b1;
    tick(); tick();
    continue_button = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_output("glitch_halted", 32'(halted), 32'd1);
    check_output("glitch_pc", 32'(pc), 32'h0ABC);

    // Button press/release in RUN is discarded, not queued
    apply_stimulus(1, 3'd5, 1, 0, 16'h0DEF);
    tick();
    check_output("exit_halt_pc", 32'(pc), 32'd50);
    apply_stimulus(0, 3'd0, 1, 0, 16'h0DEF);
    continue_button = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    continue_button = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_output("run_press_pc", 32'(pc), 32'd50);
    apply_stimulus(0, 3'd0, 0, 1, 16'h0DEF);
    tick();
    apply_stimulus(0, 3'd0, 1, 0, 16'h0DEF);
    for (int i = 0; i < 20; i++) tick();
    check_output("no_queued_evt", 32'(halted), 32'd1);

    // Press in RUN, release in HALT resumes
    apply_stimulus(1, 3'd0, 1, 0, 16'h0777);
    tick();
    apply_stimulus(0, 3'd0, 1, 0, 16'h0777);
    continue_button = 1'b1;
    tick(); tick(); tick();
    apply_stimulus(0, 3'd0, 0, 1, 16'h0777);
    tick();
    check_output("span_halted", 32'(halted), 32'd1);
    apply_stimulus(0, 3'd0, 1, 0, 16'h0777);
    for (int i = 0; i < 6; i++) tick();
    continue_button = 1'b0;
    wait_resume("span_resume");
    check_output("span_pc", 32'(pc), 32'h0777);
    check_output("span_cnt", 32'(instr_count), 32'd1);

    // Out-of-range index and wrapping entry arithmetic on the N_ENTRY=5 copy
    apply_stimulus(1, 3'd6, 1, 0, 16'h0777);
    tick();
    check_output("n5_oob_pc", 32'(pc_n), 32'd250);
    check_output("dflt_tn6_pc", 32'(pc), 32'd60);
    apply_stimulus(1, 3'd4, 1, 0, 16'h0777);
    tick();
    check_output("n5_wrap_pc", 32'(pc_n), 32'd6);
    check_output("dflt_tn4_pc", 32'(pc), 32'd40);

    // Saturation: 20 advances on a 4-bit counter
    apply_stimulus(0, 3'd0, 0, 0, 16'h0010);
    for (int i = 0; i < 20; i++) tick();
    check_output("cnt16_20", 32'(instr_count), 32'd20);
    check_output("cnt4_sat", 32'(instr_count4), 32'd15);

    // Asynchronous reset in HALT, mid-debounce
    apply_stimulus(0, 3'd0, 0, 1, 16'h0010);
    tick();
    check_output("pre_rst_halted", 32'(halted), 32'd1);
    apply_stimulus(0, 3'd0, 1, 0, 16'h0040);
    continue_button = 1'b1;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check_output("async_rst_pc", 32'(pc), 32'h0);
    check_output("async_rst_h", 32'(halted), 32'd0);
    check_output("async_rst_cnt", 32'(instr_count), 32'd0);
    continue_button = 1'b0;
    tick();
    apply_stimulus(0, 3'd0, 0, 0, 16'h0040);
    reset = 1'b1;
    tick();
    check_output("post_rst_pc", 32'(pc), 32'h0040);
    check_output("post_rst_cnt", 32'(instr_count), 32'd1);
    check_output("post_rst_h", 32'(halted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16: PC width in bits.
REQ-002 SHALL have parameter N_ENTRY, default 8: number of selectable test entry points.
REQ-003 SHALL have parameter ENTRY_BASE, default 0: PC of entry 0.
REQ-004 SHALL have parameter ENTRY_STRIDE, default 10: PC distance between consecutive entries.
REQ-005 SHALL have parameter DEB_CYC, default 4: clocks a button level must hold stable before it is accepted.
REQ-006 SHALL have parameter CNT_W, default 16: instruction-counter width.
REQ-007 SHALL have port clock  in  1  system clock; one clock domain.
REQ-008 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port ecall  in  1  current instruction is ecall.
REQ-010 SHALL have port continue_button  in  1  raw, asynchronous, active-high push button.
REQ-011 SHALL have port pc_change  in  1  load the selected test entry.
REQ-012 SHALL have port stall  in  1  hold the PC this cycle.
REQ-013 SHALL have port target_pc  in  PC_W  next PC from the datapath.
REQ-014 SHALL have port test_number  in  max(1,$clog2(N_ENTRY))  entry index.
REQ-015 SHALL have port pc  out  PC_W  current PC.
REQ-016 SHALL have port halted  out  1  high while in HALT.
REQ-017 SHALL have port instr_count  out  CNT_W  number of retired PC advances.

Function
REQ-018 All state SHALL update on the falling edge of clock, so the datapath samples pc on the rising edge.
REQ-019 Entry k SHALL equal ENTRY_BASE + k*ENTRY_STRIDE, computed modulo 2^PC_W; there is no storage table.
REQ-020 A test_number >= N_ENTRY SHALL select entry 0.
REQ-021 The FSM SHALL have exactly two states, RUN and HALT.
REQ-022 Per-edge priority SHALL be: pc_change > HALT handling > stall > ecall > advance.
REQ-023 pc_change in any state SHALL load pc with the selected entry, enter RUN, and clear instr_count.
REQ-024 In RUN with stall=1, pc and instr_count SHALL hold.
REQ-025 In RUN with ecall=1, pc SHALL hold and the FSM SHALL enter HALT on that edge.
REQ-026 In RUN with ecall=0 and stall=0, pc SHALL load target_pc and instr_count SHALL increment.
REQ-027 In HALT, pc SHALL hold regardless of stall, ecall and target_pc.
REQ-028 In HALT, a continue event SHALL load target_pc, increment instr_count, and return the FSM to RUN.
REQ-029 continue_button SHALL pass through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEB_CYC consecutive identical samples.
REQ-030 A continue event SHALL be a 1-clock pulse generated on the debounced falling edge (button release).
REQ-031 Continue events occurring in RUN SHALL be discarded, not queued.
REQ-032 A press-and-release spanning entry into HALT SHALL resume only if the release occurs while in HALT.
REQ-033 Glitches shorter than DEB_CYC clocks SHALL produce no event.
REQ-034 instr_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-035 pc SHALL wrap naturally on target_pc or entry arithmetic; no overflow flag is produced.
REQ-036 halted SHALL be a registered output equal to (state==HALT).

Reset
REQ-037 reset=0 SHALL immediately force pc=ENTRY_BASE, state=RUN, halted=0, instr_count=0.
REQ-038 reset=0 SHALL immediately clear the synchroniser and debouncer to the released (0) level and zero the debounce counter.
REQ-039 Reset asserted in HALT or mid-debounce SHALL discard all pending state; release SHALL resume in RUN on the next falling edge.

Structure
REQ-040 A shared package fetch_pkg SHALL hold the state enum (RUN, HALT) and the default parameter constants.
REQ-041 The synchroniser, debouncer and falling-edge detector SHALL be one sub-module, btn_debounce, parameterised by DEB_CYC, with a 1-cycle event output.
REQ-042 The entry computation SHALL be a function in fetch_pkg.

Verification
REQ-043 Reset release, ecall=0, target_pc=0x0004 for 3 edges -> pc=0x0004, instr_count=3, halted=0.
REQ-044 pc_change=1, test_number=3 (defaults) -> pc=30 on that edge, instr_count=0; test_number=7 -> pc=70.
REQ-045 ecall=1 in RUN -> halted=1 and pc held for 50 clocks; button press 10 clocks then release -> after sync+DEB_CYC latency, pc=target_pc and halted=0.
REQ-046 In HALT, a 2-clock button pulse (< DEB_CYC) -> no resume, halted stays 1; a button pulse in RUN -> no effect on a later HALT.
REQ-047 stall=1 together with pc_change=1 -> entry loaded; stall=1 alone -> pc and instr_count unchanged.
REQ-048 CNT_W=4, 20 advances -> instr_count=15; reset=0 asserted in HALT mid-debounce -> pc=ENTRY_BASE, halted=0 asynchronously.
